// File: rtl/scan_sel_sequencer.sv
// ---------------------------------------------------------------------------
// scan_sel_sequencer
//
// Produces the 3-bit channel select for a downstream 3-to-8 one-hot decoder.
// A prescaler generates a step every div_val+1 enabled cycles.
// On each step the select advances to the next channel that is enabled in
// ch_mask, searching in ascending order and wrapping around.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   scan enable; when low the prescaler is held at 0 and
//                   sel is frozen
//   div_val    in   step period minus 1, in clk cycles
//   ch_mask    in   channel enable mask, bit i = channel i participates
//   sel        out  current channel index (registered)
//   sel_valid  out  sel names an enabled channel and scanning is active
//   tick       out  one-cycle pulse in the cycle sel takes a new value
//   wrap       out  one-cycle pulse on the tick that completes a scan pass
//
// Handshake: there is none. All outputs are plain registered strobes or
// levels, and they have no combinational path from any input.
// ---------------------------------------------------------------------------
module scan_sel_sequencer #(
  parameter int DIV_WIDTH = 16,
  parameter int NUM_CH    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div_val,
  input  logic [NUM_CH-1:0]    ch_mask,
  output logic [2:0]           sel,
  output logic                 sel_valid,
  output logic                 tick,
  output logic                 wrap
);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic [2:0]           r_sel;
  logic                 r_sel_valid;
  logic                 r_tick;
  logic                 r_wrap;

  logic                 w_step;
  logic [2:0]           w_start;
  logic [2:0]           w_idx;
  logic                 w_found;
  logic [2:0]           w_found_sel;

  logic [DIV_WIDTH-1:0] w_cnt_nxt;
  logic [2:0]           w_sel_nxt;
  logic                 w_valid_nxt;
  logic                 w_tick_nxt;
  logic                 w_wrap_nxt;

  // The >= compare means a div_val lowered below the running count steps on
  // the very next edge, and the counter can never run past div_val.
  assign w_step = en && (r_cnt >= div_val);

  // Circular search for the next enabled channel. While sel is valid the
  // current channel has already been served, so the search starts one past
  // it. Otherwise the current channel is still a candidate, which lets a
  // re-enabled channel be picked up again in place. The 3-bit index wraps
  // modulo 8 by itself.
  always_comb begin
    w_start     = r_sel_valid ? (r_sel + 3'd1) : r_sel;
    w_idx       = w_start;
    w_found     = 1'b0;
    w_found_sel = r_sel;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = w_start + 3'(i);
      if (!w_found && ch_mask[w_idx]) begin
        w_found     = 1'b1;
        w_found_sel = w_idx;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_cnt_nxt   = r_cnt + DIV_WIDTH'(1);
    w_sel_nxt   = r_sel;
    // On a non-step cycle a channel that has been masked off loses validity.
    // Validity is only regained on a step.
    w_valid_nxt = r_sel_valid & ch_mask[r_sel];
    w_tick_nxt  = 1'b0;
    w_wrap_nxt  = 1'b0;

    if (!en) begin
      w_cnt_nxt   = '0;
      w_valid_nxt = 1'b0;
    end else if (w_step) begin
      w_cnt_nxt = '0;
      if (w_found) begin
        w_sel_nxt   = w_found_sel;
        w_valid_nxt = 1'b1;
        w_tick_nxt  = 1'b1;
        // A pass is complete when the search went round past channel 7. A
        // mask with a single enabled channel therefore wraps on every step.
        w_wrap_nxt  = r_sel_valid && (w_found_sel <= r_sel);
      end else begin
        // Empty mask: hold sel, report nothing.
        w_valid_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_sel       <= '0;
      r_sel_valid <= 1'b0;
      r_tick      <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_sel       <= w_sel_nxt;
      r_sel_valid <= w_valid_nxt;
      r_tick      <= w_tick_nxt;
      r_wrap      <= w_wrap_nxt;
    end
  end

  assign sel       = r_sel;
  assign sel_valid = r_sel_valid;
  assign tick      = r_tick;
  assign wrap      = r_wrap;

endmodule
